bit_serial_adder: RTL



---
 rtl/bsa_pkg.sv | 14 +
 rtl/ha_cell.sv | 15 +
 rtl/bit_serial_adder.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/bsa_pkg.sv
// Shared definitions for the bit-serial adder.
//   WIDTH_MAX   : largest supported operand width
//   bsa_state_e : controller states (idle, shifting bits, result strobe)
package bsa_pkg;

   localparam int unsigned WIDTH_MAX = 32;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StShift = 2'd1,
      StDone  = 2'd2
   } bsa_state_e;

endpackage

// File: rtl/ha_cell.sv
// Single-bit combinational half adder.
//   x, y : input bits
//   s    : sum bit   (x ^ y)
//   c    : carry bit (x & y)
module ha_cell (
   input  logic x,
   input  logic y,
   output logic s,
   output logic c
);

   assign s = x ^ y;
   assign c = x & y;

endmodule

// File: rtl/bit_serial_adder.sv
// Bit-serial adder: adds two WIDTH-bit operands one bit per clock, LSB first,
// using two half-adder cells as the full adder.
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset
//   start     : begin an addition (ignored while busy)
//   a, b      : operands, captured on the accepting edge
//   busy      : high while bits are being processed
//   ser_bit   : serial sum bit, LSB first, qualified by ser_valid
//   ser_valid : qualifies ser_bit
//   done      : one-cycle strobe, sum/cout valid from this cycle on
//   sum, cout : parallel result and carry out, held until next completion
module bit_serial_adder
   import bsa_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             ser_bit,
   output logic             ser_valid,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   if (WIDTH < 2 || WIDTH > WIDTH_MAX) begin : gen_bad_width
      $fatal(1, "bit_serial_adder: WIDTH out of range");
   end

   localparam int unsigned     CntW    = $clog2(WIDTH);
   localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

   bsa_state_e       state_q, state_d;
   logic [WIDTH-1:0] a_sr_q, a_sr_d;
   logic [WIDTH-1:0] b_sr_q, b_sr_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             busy_q, busy_d;
   logic             ser_bit_q, ser_bit_d;
   logic             ser_valid_q, ser_valid_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;

   // Full adder built from two half-adder cells.
   logic ha0_s, ha0_c, fa_s, ha1_c, fa_c;

   ha_cell u_ha0 (
      .x (a_sr_q[0]),
      .y (b_sr_q[0]),
      .s (ha0_s),
      .c (ha0_c)
   );

   ha_cell u_ha1 (
      .x (ha0_s),
      .y (carry_q),
      .s (fa_s),
      .c (ha1_c)
   );

   assign fa_c = ha0_c | ha1_c;

   always_comb begin
      state_d     = state_q;
      a_sr_d      = a_sr_q;
      b_sr_d      = b_sr_q;
      res_d       = res_q;
      cnt_d       = cnt_q;
      carry_d     = carry_q;
      busy_d      = busy_q;
      ser_bit_d   = ser_bit_q;
      ser_valid_d = 1'b0;
      done_d      = 1'b0;
      sum_d       = sum_q;
      cout_d      = cout_q;

      unique case (state_q)
         StIdle, StDone: begin
            if (start) begin
               state_d = StShift;
               a_sr_d  = a;
               b_sr_d  = b;
               carry_d = 1'b0;
               cnt_d   = '0;
               busy_d  = 1'b1;
            end else begin
               state_d = StIdle;
            end
         end
         StShift: begin
            // Sum bits enter at the MSB so bit 0 lands at position 0 after WIDTH shifts.
            res_d       = {fa_s, res_q[WIDTH-1:1]};
            a_sr_d      = a_sr_q >> 1;
            b_sr_d      = b_sr_q >> 1;
            carry_d     = fa_c;
            cnt_d       = cnt_q + 1'b1;
            ser_bit_d   = fa_s;
            ser_valid_d = 1'b1;
            if (cnt_q == CntLast) begin
               state_d = StDone;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               sum_d   = res_d;
               cout_d  = fa_c;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = StIdle;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         a_sr_q      <= '0;
         b_sr_q      <= '0;
         res_q       <= '0;
         cnt_q       <= '0;
         carry_q     <= 1'b0;
         busy_q      <= 1'b0;
         ser_bit_q   <= 1'b0;
         ser_valid_q <= 1'b0;
         done_q      <= 1'b0;
         sum_q       <= '0;
         cout_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_sr_q      <= a_sr_d;
         b_sr_q      <= b_sr_d;
         res_q       <= res_d;
         cnt_q       <= cnt_d;
         carry_q     <= carry_d;
         busy_q      <= busy_d;
         ser_bit_q   <= ser_bit_d;
         ser_valid_q <= ser_valid_d;
         done_q      <= done_d;
         sum_q       <= sum_d;
         cout_q      <= cout_d;
      end
   end

   assign busy      = busy_q;
   assign ser_bit   = ser_bit_q;
   assign ser_valid = ser_valid_q;
   assign done      = done_q;
   assign sum       = sum_q;
   assign cout      = cout_q;

endmodule
